// File: rtl/memory_if.sv
// Write/read port bundle for the simple dual-port memory.
// The master drives strobes, addresses and write data; the slave returns the registered read data.
interface memory_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 10
);
  logic                  write_en;
  logic [ADDR_WIDTH-1:0] write_address;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  read_en;
  logic [ADDR_WIDTH-1:0] read_address;
  logic [DATA_WIDTH-1:0] data_out;

  modport master (
    output write_en, write_address, data_in, read_en, read_address,
    input  data_out
  );

  modport slave (
    input  write_en, write_address, data_in, read_en, read_address,
    output data_out
  );
endinterface

// File: rtl/memory.sv
// Single-write / single-read word memory with a registered read port and synchronous active-low reset.
// Define MEMORY_RDW_BYPASS_EN to forward write data to a same-cycle read of the same address.
module memory #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MEM_SIZE   = 1024,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic     clk,
  input  logic     rst_n,
  memory_if.slave  bus
);

  localparam int unsigned IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  // One extra bit so the range check also works when MEM_SIZE == 2**ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(MEM_SIZE);

  logic [DATA_WIDTH-1:0] mem_q [MEM_SIZE];
  logic [DATA_WIDTH-1:0] data_out_q;
  logic [DATA_WIDTH-1:0] data_out_d;

  logic                  wr_valid_c;
  logic                  rd_valid_c;
  logic [IDX_W-1:0]      wr_idx_c;
  logic [IDX_W-1:0]      rd_idx_c;
  logic                  wr_en_c;
  logic [DATA_WIDTH-1:0] wr_data_c;

  // Address decode: out-of-range addresses never reach the array index.
  always_comb begin
    wr_valid_c = ({1'b0, bus.write_address} < DEPTH);
    rd_valid_c = ({1'b0, bus.read_address} < DEPTH);
    wr_idx_c   = IDX_W'(bus.write_address);
    rd_idx_c   = IDX_W'(bus.read_address);
  end

  // Next-state for the write port and the read register; reset overrides both strobes.
  always_comb begin
    wr_en_c    = 1'b0;
    wr_data_c  = bus.data_in;
    data_out_d = data_out_q;

    if (!rst_n) begin
      wr_en_c    = wr_valid_c;
      wr_data_c  = '0;
      data_out_d = '0;
    end else begin
      wr_en_c = bus.write_en && wr_valid_c;
      if (bus.read_en) begin
        if (!rd_valid_c) begin
          data_out_d = '0;
`ifdef MEMORY_RDW_BYPASS_EN
        end else if (wr_en_c && (bus.write_address == bus.read_address)) begin
          data_out_d = bus.data_in;
`endif
        end else begin
          data_out_d = mem_q[rd_idx_c];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    data_out_q <= data_out_d;
  end

  // Storage array carries no reset; only the addressed word is cleared during reset.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem_q[wr_idx_c] <= wr_data_c;
    end
  end

  assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_memory.sv
// Scoreboard bench for memory: stimulus updates a word-level model and queues the expected data_out,
// a monitor compares after every clock edge that stimulus drove.
module tb_memory;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 10;
  localparam int unsigned MS = 1000;

`ifdef MEMORY_RDW_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  memory #(.DATA_WIDTH(DW), .MEM_SIZE(MS), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int    value;
    string name;
  } exp_t;

  exp_t exp_q[$];
  int   model [1024];
  int   cur_out;
  int   total = 0;
  int   bad = 0;

  // One clock of stimulus; model is -1 for undefined words / output.
  task automatic step(input bit rst, input bit we, input int wa, input int din,
                      input bit re, input int ra, input string name);
    exp_t e;
    @(negedge clk);
    rst_n             = rst;
    bus.write_en      = we;
    bus.write_address = AW'(wa);
    bus.data_in       = DW'(din);
    bus.read_en       = re;
    bus.read_address  = AW'(ra);
    if (!rst) begin
      cur_out = 0;
      if (wa < int'(MS)) model[wa] = 0;
    end else begin
      if (re) begin
        if (ra >= int'(MS))                   cur_out = 0;
        else if (BYPASS && we && wa == ra)    cur_out = din;
        else                                  cur_out = model[ra];
      end
      if (we && wa < int'(MS)) model[wa] = din;
    end
    e.value = cur_out;
    e.name  = name;
    exp_q.push_back(e);
  endtask

  function automatic int pick_addr();
    if ($urandom_range(0, 4) == 0) return int'($urandom_range(990, 1023));
    return int'($urandom_range(0, 31));
  endfunction

  // Monitor: data_out is valid one step after each driven edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.value >= 0) begin
          total++;
          if (bus.data_out !== DW'(e.value)) begin
            bad++;
            $display("FAIL %s: data_out=%h expected=%h", e.name, bus.data_out, DW'(e.value));
          end
        end
      end
    end
  end

  initial begin
    int v_lo [4] = '{'hEF, 'hBE, 'hAD, 'hDE};
    int v_hi [4] = '{'h78, 'h56, 'h34, 'h12};
    bit r, w, rd;

    foreach (model[i]) model[i] = -1;
    cur_out           = -1;
    bus.write_en      = 1'b0;
    bus.write_address = '0;
    bus.data_in       = '0;
    bus.read_en       = 1'b0;
    bus.read_address  = '0;

    step(0, 0, 0, 0, 0, 0, "reset");
    step(0, 0, 0, 0, 0, 0, "reset");

    for (int i = 0; i < 4; i++) step(1, 1, i, v_lo[i], 0, 0, "hold_wr");
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1, i, "rd_lo");

    for (int i = 0; i < 4; i++) step(1, 1, 4 + i, v_hi[i], 0, 0, "hold_wr");
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1, 4 + i, "rd_hi");
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1, i, "rd_lo_again");

    step(1, 1, 10, 'h3C, 0, 0, "hold_wr");

    step(1, 0, 0, 0, 1, 2, "rd2");
    step(1, 1, 2, 'h55, 0, 0, "hold_ad");
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, "hold_ad");
    step(1, 0, 0, 0, 1, 2, "rd2_new");

    step(1, 1, 5, 'h99, 1, 5, "rdw_same");
    step(1, 0, 0, 0, 1, 5, "rd5_after");

    step(0, 1, 1, 'h77, 0, 0, "rst_out");
    step(1, 0, 0, 0, 1, 1, "rst_clr");
    step(1, 0, 0, 0, 1, 0, "rst_keep");

    step(1, 1, 1010, 'hAA, 0, 0, "oor_wr");
    step(1, 0, 0, 0, 1, 1010, "oor_rd");
    step(1, 0, 0, 0, 1, 10, "no_alias");

    for (int i = 0; i < 32; i++) step(1, 1, i, int'($urandom_range(0, 255)), 0, 0, "fill");
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 49) != 0);
      w  = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      step(r, w, pick_addr(), int'($urandom_range(0, 255)), rd, pick_addr(), "random");
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
